// File: rtl/stopwatch_bcd_core_if.sv
// Stopwatch core bus: tick/button levels in, BCD digits and status flags out.
interface stopwatch_bcd_core_if;
  logic       tick;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic [3:0] digit5;
  logic [3:0] digit6;
  logic [3:0] digit7;
  logic [3:0] digit8;
  logic       running;
  logic       lap_active;
  logic       overflow;

  // Driver side (prescaler, button synchronizers, display consumer)
  modport master (
    output tick, start_stop, lap, clear,
    input  digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8,
    input  running, lap_active, overflow
  );

  // Stopwatch core side
  modport slave (
    input  tick, start_stop, lap, clear,
    output digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8,
    output running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_bcd_core.sv
// Stopwatch timekeeping core: cascaded BCD hh:mm:ss.cc counter advanced on a
// 0.01 s tick, with start/stop, lap-freeze and clear commands taken from
// rising edges of synchronized button levels.
module stopwatch_bcd_core #(
  parameter int unsigned HOUR_LIMIT = 100
) (
  input logic                 clock,
  input logic                 reset,
  stopwatch_bcd_core_if.slave bus
);

  // Highest legal hours value, split into BCD tens/units
  localparam logic [3:0] HrTens  = 4'((HOUR_LIMIT - 1) / 10);
  localparam logic [3:0] HrUnits = 4'((HOUR_LIMIT - 1) % 10);

  // Per-digit rollover value for the six sub-hour digits (index 0 = hundredths units)
  localparam logic [5:0][3:0] DigitMax = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e          r_state;
  state_e          w_state_d;

  logic            r_ss_hist;
  logic            r_lap_hist;
  logic            r_clr_hist;
  logic            w_ss_rise;
  logic            w_lap_rise;
  logic            w_clr_rise;
  logic            w_ss_cmd;
  logic            w_lap_cmd;
  logic            w_zero;

  logic [7:0][3:0] r_cnt;
  logic [7:0][3:0] w_cnt_inc;
  logic [7:0][3:0] w_cnt_d;
  logic [7:0][3:0] r_lap;
  logic [7:0][3:0] w_lap_d;
  logic            r_lap_active;
  logic            w_lap_active_d;
  logic            r_overflow;
  logic            w_overflow_d;
  logic            w_carry;
  logic            w_wrap;

  logic [7:0][3:0] w_disp;
  logic            w_running;

  assign w_ss_rise  = bus.start_stop & ~r_ss_hist;
  assign w_lap_rise = bus.lap        & ~r_lap_hist;
  assign w_clr_rise = bus.clear      & ~r_clr_hist;

  // Priority clear > start_stop > lap; losers in the same cycle are dropped
  assign w_ss_cmd  = w_ss_rise  & ~w_clr_rise;
  assign w_lap_cmd = w_lap_rise & ~w_clr_rise & ~w_ss_rise;

  // Clear only acts outside RUN
  assign w_zero = w_clr_rise && (r_state != StRun);

  // Button history flops for rising-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ss_hist  <= 1'b0;
      r_lap_hist <= 1'b0;
      r_clr_hist <= 1'b0;
    end else begin
      r_ss_hist  <= bus.start_stop;
      r_lap_hist <= bus.lap;
      r_clr_hist <= bus.clear;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_ss_cmd) w_state_d = StRun;
      StRun:   if (w_ss_cmd) w_state_d = StPause;
      StPause: begin
        if (w_ss_cmd)        w_state_d = StRun;
        else if (w_clr_rise) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_running = (r_state == StRun);
  end

  // BCD incrementer: ripple carry through the sub-hour digits, then hours wrap
  always_comb begin
    w_cnt_inc = r_cnt;
    w_carry   = 1'b1;
    w_wrap    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (w_carry) begin
        if (r_cnt[i] == DigitMax[i]) begin
          w_cnt_inc[i] = 4'd0;
        end else begin
          w_cnt_inc[i] = r_cnt[i] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
    if (w_carry) begin
      if (r_cnt[7] == HrTens && r_cnt[6] == HrUnits) begin
        w_cnt_inc[7] = 4'd0;
        w_cnt_inc[6] = 4'd0;
        w_wrap       = 1'b1;
      end else if (r_cnt[6] == 4'd9) begin
        w_cnt_inc[6] = 4'd0;
        w_cnt_inc[7] = r_cnt[7] + 4'd1;
      end else begin
        w_cnt_inc[6] = r_cnt[6] + 4'd1;
      end
    end
  end

  // Count, lap and flag next-state; decisions use the pre-transition state
  always_comb begin
    w_cnt_d        = r_cnt;
    w_lap_d        = r_lap;
    w_lap_active_d = r_lap_active;
    w_overflow_d   = r_overflow;
    if (r_state == StRun && bus.tick) begin
      w_cnt_d = w_cnt_inc;
      if (w_wrap) w_overflow_d = 1'b1;
    end
    if (w_lap_cmd) begin
      if (r_state == StRun && !r_lap_active) begin
        // Capture the pre-tick count so a same-cycle tick only hits the live value
        w_lap_d        = r_cnt;
        w_lap_active_d = 1'b1;
      end else begin
        w_lap_active_d = 1'b0;
      end
    end
    if (w_zero) begin
      w_cnt_d        = '0;
      w_lap_d        = '0;
      w_lap_active_d = 1'b0;
      w_overflow_d   = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt        <= '0;
      r_lap        <= '0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_lap        <= w_lap_d;
      r_lap_active <= w_lap_active_d;
      r_overflow   <= w_overflow_d;
    end
  end

  // Display mux: both sources are registers, so no tick/button path reaches the digits
  always_comb begin
    w_disp = r_lap_active ? r_lap : r_cnt;
  end

  assign bus.digit1     = w_disp[0];
  assign bus.digit2     = w_disp[1];
  assign bus.digit3     = w_disp[2];
  assign bus.digit4     = w_disp[3];
  assign bus.digit5     = w_disp[4];
  assign bus.digit6     = w_disp[5];
  assign bus.digit7     = w_disp[6];
  assign bus.digit8     = w_disp[7];
  assign bus.running    = w_running;
  assign bus.lap_active = r_lap_active;
  assign bus.overflow   = r_overflow;

endmodule
